// File: rtl/tap_dr_bank.sv
// JTAG data-register bank: bypass, IDCODE, USERCODE and boundary-scan registers,
// with instruction decode, pin/core muxing and a negedge-retimed TDO.
module tap_dr_bank #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 4,
    parameter logic [31:0] ID_VALUE   = 32'h4BA1_00A1,
    parameter int unsigned USER_WIDTH = 32,
    parameter logic [31:0] USER_VALUE = 32'h0000_00A1
) (
    input  logic                TRST,
    input  logic                TCK,
    input  logic                TDI,
    input  logic [IR_WIDTH-1:0] IR,
    input  logic                TLR,
    input  logic                CAPTURE_DR,
    input  logic                SHIFT_DR,
    input  logic                UPDATE_DR,
    input  logic [N_IN-1:0]     PIN_IN,
    input  logic [N_OUT-1:0]    CORE_DOUT,
    input  logic                CORE_OE,
    output logic [N_OUT-1:0]    PIN_OUT,
    output logic                PIN_OE,
    output logic [N_IN-1:0]     CORE_DIN,
    output logic                TDO,
    output logic                TDO_EN
);

    localparam int unsigned BSR_W  = N_IN + N_OUT + 1;
    localparam int unsigned OE_IDX = BSR_W - 1;

    localparam logic [31:0]           ID_CAP   = ID_VALUE | 32'h0000_0001;
    localparam logic [USER_WIDTH-1:0] USER_CAP = USER_WIDTH'(USER_VALUE);

    typedef enum logic [2:0] {
        I_EXTEST,
        I_SAMPLE,
        I_IDCODE,
        I_USERCODE,
        I_INTEST,
        I_CLAMP,
        I_HIGHZ,
        I_BYPASS
    } instr_e;

    typedef enum logic [1:0] {
        SEL_BYP,
        SEL_ID,
        SEL_USER,
        SEL_BSR
    } dr_sel_e;

    instr_e  instr;
    dr_sel_e sel;

    logic                  byp;
    logic [31:0]           id_reg;
    logic [USER_WIDTH-1:0] user_reg;
    logic [BSR_W-1:0]      bsr;
    logic [BSR_W-1:0]      upd;
    logic [BSR_W-1:0]      bsr_cap;
    logic                  sel_lsb;
    logic                  drive_upd;

    // Undefined codes, including any with upper IR bits set, fall through to BYPASS.
    always_comb begin
        instr = I_BYPASS;
        if      (IR == IR_WIDTH'(0)) instr = I_EXTEST;
        else if (IR == IR_WIDTH'(1)) instr = I_SAMPLE;
        else if (IR == IR_WIDTH'(2)) instr = I_IDCODE;
        else if (IR == IR_WIDTH'(3)) instr = I_USERCODE;
        else if (IR == IR_WIDTH'(4)) instr = I_INTEST;
        else if (IR == IR_WIDTH'(5)) instr = I_CLAMP;
        else if (IR == IR_WIDTH'(6)) instr = I_HIGHZ;
    end

    always_comb begin
        sel = SEL_BYP;
        case (instr)
            I_EXTEST, I_SAMPLE, I_INTEST: sel = SEL_BSR;
            I_IDCODE:                     sel = SEL_ID;
            I_USERCODE:                   sel = SEL_USER;
            default:                      sel = SEL_BYP;
        endcase
    end

    // Per-bit loops keep the cell layout free of slices that vanish when N_IN or N_OUT is 0.
    always_comb begin
        bsr_cap = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            bsr_cap[i] = (instr == I_INTEST) ? upd[i] : PIN_IN[i];
        end
        for (int unsigned i = 0; i < N_OUT; i++) begin
            bsr_cap[N_IN + i] = CORE_DOUT[i];
        end
        bsr_cap[OE_IDX] = CORE_OE;
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            byp      <= 1'b0;
            id_reg   <= ID_CAP;
            user_reg <= USER_CAP;
            bsr      <= '0;
            upd      <= '0;
        end else if (TLR) begin
            byp      <= 1'b0;
            id_reg   <= ID_CAP;
            user_reg <= USER_CAP;
            bsr      <= '0;
            upd      <= '0;
        end else if (CAPTURE_DR) begin
            case (sel)
                SEL_BYP:  byp      <= 1'b0;
                SEL_ID:   id_reg   <= ID_CAP;
                SEL_USER: user_reg <= USER_CAP;
                default:  bsr      <= bsr_cap;
            endcase
        end else if (SHIFT_DR) begin
            case (sel)
                SEL_BYP:  byp      <= TDI;
                SEL_ID:   id_reg   <= {TDI, id_reg[31:1]};
                SEL_USER: user_reg <= USER_WIDTH'({TDI, user_reg} >> 1);
                default:  bsr      <= BSR_W'({TDI, bsr} >> 1);
            endcase
        end else if (UPDATE_DR && (sel == SEL_BSR)) begin
            upd <= bsr;
        end
    end

    assign drive_upd = (instr == I_EXTEST) || (instr == I_CLAMP);

    always_comb begin
        PIN_OUT  = CORE_DOUT;
        PIN_OE   = CORE_OE;
        CORE_DIN = PIN_IN;
        if (drive_upd) begin
            for (int unsigned i = 0; i < N_OUT; i++) begin
                PIN_OUT[i] = upd[N_IN + i];
            end
            PIN_OE = upd[OE_IDX];
        end
        if (instr == I_HIGHZ) begin
            PIN_OE = 1'b0;
        end
        if (instr == I_INTEST) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                CORE_DIN[i] = upd[i];
            end
        end
    end

    always_comb begin
        sel_lsb = byp;
        case (sel)
            SEL_ID:   sel_lsb = id_reg[0];
            SEL_USER: sel_lsb = user_reg[0];
            SEL_BSR:  sel_lsb = bsr[0];
            default:  sel_lsb = byp;
        endcase
    end

    // Falling-edge retiming; TLR deliberately leaves TDO alone.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO_EN <= SHIFT_DR;
            if (SHIFT_DR) begin
                TDO <= sel_lsb;
            end
        end
    end

endmodule

// File: tb/tb_tap_dr_bank.sv
// Directed bench for tap_dr_bank: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_tap_dr_bank;

    logic       TRST;
    logic       TCK;
    logic       TDI;
    logic [3:0] IR;
    logic       TLR;
    logic       CAPTURE_DR;
    logic       SHIFT_DR;
    logic       UPDATE_DR;
    logic [3:0] PIN_IN;
    logic [3:0] CORE_DOUT;
    logic       CORE_OE;
    logic [3:0] PIN_OUT;
    logic       PIN_OE;
    logic [3:0] CORE_DIN;
    logic       TDO;
    logic       TDO_EN;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];

    tap_dr_bank #(
        .IR_WIDTH  (4),
        .N_IN      (4),
        .N_OUT     (4),
        .ID_VALUE  (32'h4BA1_00A1),
        .USER_WIDTH(32),
        .USER_VALUE(32'h0000_00A1)
    ) dut (
        .TRST      (TRST),
        .TCK       (TCK),
        .TDI       (TDI),
        .IR        (IR),
        .TLR       (TLR),
        .CAPTURE_DR(CAPTURE_DR),
        .SHIFT_DR  (SHIFT_DR),
        .UPDATE_DR (UPDATE_DR),
        .PIN_IN    (PIN_IN),
        .CORE_DOUT (CORE_DOUT),
        .CORE_OE   (CORE_OE),
        .PIN_OUT   (PIN_OUT),
        .PIN_OE    (PIN_OE),
        .CORE_DIN  (CORE_DIN),
        .TDO       (TDO),
        .TDO_EN    (TDO_EN)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    task automatic capture();
        CAPTURE_DR = 1'b1;
        tick();
        CAPTURE_DR = 1'b0;
    endtask

    task automatic update();
        UPDATE_DR = 1'b1;
        tick();
        UPDATE_DR = 1'b0;
    endtask

    // Entered just after a posedge; each cycle samples TDO at the negedge
    // before the shifting posedge.
    task automatic shift_seq(input int unsigned n, input logic [63:0] tdi_bits,
                             input logic [63:0] exp_tdo, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            SHIFT_DR = 1'b1;
            TDI      = tdi_bits[i];
            exp_q.push_back(32'(exp_tdo[i]));
            exp_q.push_back(32'd1);
            @(negedge TCK);
            #1;
            check(tag, 32'(TDO));
            check({tag, "_en"}, 32'(TDO_EN));
            tick();
        end
        SHIFT_DR = 1'b0;
    endtask

    task automatic check_pins(input string tag, input logic [3:0] e_out,
                              input logic e_oe, input logic [3:0] e_din);
        exp_q.push_back(32'(e_out));
        exp_q.push_back(32'(e_oe));
        exp_q.push_back(32'(e_din));
        #1;
        check({tag, "_pin_out"}, 32'(PIN_OUT));
        check({tag, "_pin_oe"}, 32'(PIN_OE));
        check({tag, "_core_din"}, 32'(CORE_DIN));
    endtask

    initial begin
        logic [31:0] id_val;
        logic [63:0] rnd;
        logic [63:0] e;
        logic [8:0]  cap;
        logic [8:0]  pre;

        id_val = 32'h4BA1_00A1;
        pre    = 9'b1_0011_0110;

        TRST = 1'b0; TDI = 1'b0; IR = 4'h2; TLR = 1'b0;
        CAPTURE_DR = 1'b0; SHIFT_DR = 1'b0; UPDATE_DR = 1'b0;
        PIN_IN = 4'hA; CORE_DOUT = 4'h5; CORE_OE = 1'b1;

        // Reset state
        #12;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        check("rst_tdo", 32'(TDO));
        check("rst_tdo_en", 32'(TDO_EN));
        check_pins("rst", 4'h5, 1'b1, 4'hA);
        TRST = 1'b1;
        tick();

        // IDCODE, plus a 33rd shift returning the first TDI bit
        IR  = 4'h2;
        rnd = {$urandom, $urandom};
        e   = 64'(id_val);
        e[32] = rnd[0];
        capture();
        shift_seq(33, rnd, e, "idcode");
        exp_q.push_back(32'd0);
        @(negedge TCK);
        #1;
        check("idcode_en_off", 32'(TDO_EN));
        tick();

        // BYPASS: defined all-ones and an undefined code behave identically
        IR = 4'hF;
        capture();
        rnd = 64'b1101;
        shift_seq(4, rnd, {rnd[62:0], 1'b0}, "bypass_f");
        IR = 4'h9;
        capture();
        shift_seq(4, rnd, {rnd[62:0], 1'b0}, "bypass_9");

        // SAMPLE capture
        IR  = 4'h1;
        cap = {CORE_OE, CORE_DOUT, PIN_IN};
        capture();
        shift_seq(9, 64'(pre), 64'(cap), "sample");
        update();

        // EXTEST drives the preloaded values as soon as IR changes
        CORE_OE = 1'b0;
        IR = 4'h0;
        check_pins("extest", pre[7:4], pre[8], 4'hA);

        // INTEST: core sees UPD_IN, pins follow the core
        IR = 4'h4;
        check_pins("intest", 4'h5, 1'b0, pre[3:0]);
        CORE_OE = 1'b1;
        cap = {CORE_OE, CORE_DOUT, pre[3:0]};
        capture();
        shift_seq(9, 64'(pre), 64'(cap), "intest_cap");

        // HIGHZ and CLAMP with the bypass path selected
        IR = 4'h6;
        check_pins("highz", 4'h5, 1'b0, 4'hA);
        capture();
        shift_seq(2, 64'b11, 64'b10, "highz_byp");
        CORE_OE = 1'b0;
        IR = 4'h5;
        check_pins("clamp", pre[7:4], pre[8], 4'hA);
        capture();
        shift_seq(2, 64'b01, 64'b10, "clamp_byp");

        // TRST pulse in the middle of a BSR shift
        CORE_OE = 1'b1;
        IR = 4'h1;
        capture();
        SHIFT_DR = 1'b1;
        TDI = 1'b1;
        repeat (4) tick();
        @(negedge TCK);
        #1;
        TRST = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        check("trst_tdo", 32'(TDO));
        check("trst_tdo_en", 32'(TDO_EN));
        TRST = 1'b1;
        SHIFT_DR = 1'b0;
        tick();
        IR = 4'h0;
        check_pins("trst_upd", 4'h0, 1'b0, 4'hA);
        IR = 4'h1;
        shift_seq(9, 64'd0, 64'd0, "trst_bsr");

        // TLR for one cycle after a fresh preload and a partial shift
        cap = {CORE_OE, CORE_DOUT, PIN_IN};
        capture();
        shift_seq(9, 64'(pre), 64'(cap), "tlr_pre");
        update();
        IR = 4'h0;
        check_pins("tlr_before", pre[7:4], pre[8], 4'hA);
        SHIFT_DR = 1'b1;
        TDI = 1'b1;
        repeat (3) tick();
        SHIFT_DR = 1'b0;
        TLR = 1'b1;
        tick();
        TLR = 1'b0;
        check_pins("tlr_upd", 4'h0, 1'b0, 4'hA);
        shift_seq(9, 64'd0, 64'd0, "tlr_bsr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
